lectura_registros_bus: RTL

Read-side responder for the neural-network peripheral's memory-mapped register window. It is the counterpart of the write-enable decoder.
- Accepts single-cycle read strobes from the host bus and decodes the same address map.
- Returns the selected register (training coefficients, offset, input, status, neuron output) on a 32-bit read-data bus with fixed 2-cycle latency.
- Maintains a sticky "Done" flag that is cleared on read.

---
 rtl/lectura_registros_bus.sv | 93 +++++++++
 1 files changed

// File: rtl/lectura_registros_bus.sv
// Read-side responder for the neural-network register window: two-stage pipeline
// (address capture, then decode/mux) with a clear-on-read sticky Done flag.
module lectura_registros_bus #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_COEFF = 20,
  parameter logic [11:0] BASE    = 12'h800
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [11:0]                 Address,
  input  logic                        Read,
  input  logic [N_COEFF*DATA_W-1:0]   Coeffs,
  input  logic [DATA_W-1:0]           Offset,
  input  logic [DATA_W-1:0]           Entrada,
  input  logic [DATA_W-1:0]           Salida,
  input  logic                        Busy,
  input  logic                        DonePulse,
  output logic [31:0]                 ReadData,
  output logic                        ReadValid,
  output logic                        ReadError
);

  localparam logic [31:0] BASE_EXT = {20'b0, BASE};
  localparam logic [31:0] LAST_EXT = BASE_EXT + 32'(4 * N_COEFF + 12);
  localparam logic [31:0] IDX_OFF  = 32'(N_COEFF);
  localparam logic [31:0] IDX_ENT  = 32'(N_COEFF + 1);
  localparam logic [31:0] IDX_STA  = 32'(N_COEFF + 2);
  localparam logic [31:0] IDX_SAL  = 32'(N_COEFF + 3);

  logic [11:0] addr_q;
  logic        vld_q;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        rvalid_q;
  logic        done_q, done_d;

  logic [31:0] addr_ext, word_idx;
  logic        in_range, status_hit;

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
    return 32'(signed'(v));
  endfunction

  always_comb begin
    addr_ext   = {20'b0, addr_q};
    word_idx   = (addr_ext - BASE_EXT) >> 2;
    in_range   = (addr_ext >= BASE_EXT) && (addr_ext <= LAST_EXT) && (addr_q[1:0] == 2'b00);
    status_hit = vld_q && in_range && (word_idx == IDX_STA);

    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (vld_q) begin
      rdata_d = '0;
      rerr_d  = !in_range;
      if (in_range) begin
        for (int unsigned i = 0; i < N_COEFF; i++) begin
          if (word_idx == 32'(i)) rdata_d = sext(Coeffs[i*DATA_W +: DATA_W]);
        end
        if (word_idx == IDX_OFF) rdata_d = sext(Offset);
        if (word_idx == IDX_ENT) rdata_d = sext(Entrada);
        if (word_idx == IDX_STA) rdata_d = {30'b0, done_q | DonePulse, Busy};
        if (word_idx == IDX_SAL) rdata_d = sext(Salida);
      end
    end

    // A pulse coincident with a status decode is reported by that read and not retained.
    done_d = done_q | DonePulse;
    if (status_hit) done_d = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q   <= '0;
      vld_q    <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vld_q    <= Read;
      if (Read) addr_q <= Address;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rvalid_q <= vld_q;
      done_q   <= done_d;
    end
  end

  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;
  assign ReadError = rerr_q;

endmodule
